// File: rtl/fft_pkg.sv
// ============================================================================
// Module      : fft_pkg
// Description : Shared FFT constants, output-sequencer state encoding and
//               helpers for bit-reversed addressing and flattened-bus slicing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_pkg;

  // Default transform geometry shared with the FFT core.
  localparam int unsigned FFT_N      = 8;
  localparam int unsigned FFT_W      = 16;
  localparam int unsigned FFT_IW     = $clog2(FFT_N);
  // Widest index supported (N up to 64).
  localparam int unsigned FFT_MAX_IW = 6;

  // Output sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_WAIT    = 2'd2
  } ser_state_e;

  // Reverse the low 'bits' bits of 'a'; upper bits of the result are zero.
  function automatic logic [FFT_MAX_IW-1:0] bitrev(input logic [FFT_MAX_IW-1:0] a,
                                                   input int bits);
    logic [FFT_MAX_IW-1:0] r;
    logic [FFT_MAX_IW-1:0] s;
    r = '0;
    s = a;
    for (int i = 0; i < int'(FFT_MAX_IW); i++) begin
      if (i < bits) begin
        r = {r[FFT_MAX_IW-2:0], s[0]};
        s = s >> 1;
      end
    end
    return r;
  endfunction

  // LSB position of bin k on a flattened bus of w-bit bins.
  function automatic int unsigned bin_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_pace_counter.sv
// ============================================================================
// Module      : fft_pace_counter
// Description : Saturating beat-pacing counter. Counts up to RATE_DIV-1 and
//               holds; clear returns it to 0. ready_o reports that the count
//               is saturated as of the coming edge, so a registered consumer
//               can raise its valid exactly RATE_DIV cycles after a clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_pace_counter #(
  parameter int unsigned RATE_DIV = 52
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic ready_o
);

  localparam int unsigned   CW  = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CW-1:0] MAX = CW'(RATE_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and hold at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign ready_o = (cnt_d == MAX);

  // Count register; starts saturated so the first beat is not delayed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= MAX;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fft_output_serializer.sv
// ============================================================================
// Module      : fft_output_serializer
// Description : Double-buffered FFT frame capture with paced, one-bin-per-beat
//               valid/ready streaming, optional bit-reversed read order and
//               DC/Nyquist imaginary masking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_output_serializer
  import fft_pkg::*;
#(
  parameter int unsigned N        = FFT_N,
  parameter int unsigned W        = FFT_W,
  parameter int unsigned RATE_DIV = 52,
  parameter int unsigned BITREV   = 0
) (
  input  logic                  fastclk,
  input  logic                  rst,
  input  logic [N*W-1:0]        frame_re,
  input  logic [N*W-1:0]        frame_im,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic [W-1:0]          output_re,
  output logic [W-1:0]          output_im,
  output logic [$clog2(N)-1:0]  index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  overrun
);

  localparam int unsigned   IW       = $clog2(N);
  localparam logic [IW-1:0] LAST_PTR = IW'(N - 1);
  localparam logic [IW-1:0] NYQ_BIN  = IW'(N / 2);

  ser_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          act_full_q, act_full_d;
  logic          sh_full_q, sh_full_d;
  logic [W-1:0]  out_re_q, out_im_q;
  logic [IW-1:0] index_q;
  logic          out_last_q;
  logic          overrun_q;

  logic [W-1:0]  in_re [N];
  logic [W-1:0]  in_im [N];
  logic [W-1:0]  act_re_q [N];
  logic [W-1:0]  act_im_q [N];
  logic [W-1:0]  sh_re_q [N];
  logic [W-1:0]  sh_im_q [N];

  logic          hs, at_last, cap, prom, pace_ready, valid_d, load;
  logic [IW-1:0] addr_d;
  logic [W-1:0]  rd_re, rd_im;

  fft_pace_counter #(.RATE_DIV(RATE_DIV)) u_pace (
    .clk_i   (fastclk),
    .rst_i   (rst),
    .clear_i (hs),
    .ready_o (pace_ready)
  );

  // Per-bin unpack of the input buses and the two frame buffers.
  for (genvar k = 0; k < int'(N); k++) begin : g_bin
    assign in_re[k] = frame_re[bin_lsb(k, W) +: W];
    assign in_im[k] = frame_im[bin_lsb(k, W) +: W];

    // Promotion copies shadow to active; capture overwrites shadow.
    always_ff @(posedge fastclk) begin
      if (prom) begin
        act_re_q[k] <= sh_re_q[k];
        act_im_q[k] <= sh_im_q[k];
      end
      if (cap) begin
        sh_re_q[k] <= in_re[k];
        sh_im_q[k] <= in_im[k];
      end
    end
  end

  // Control: handshake, buffer bookkeeping, next pointer and next beat.
  // The active buffer counts as free on the final handshake so a waiting
  // shadow frame streams with no extra bubble.
  always_comb begin
    hs         = (state_q == ST_PRESENT) && out_ready;
    at_last    = (ptr_q == LAST_PTR);
    cap        = frame_valid && !sh_full_q;
    prom       = sh_full_q && (!act_full_q || (hs && at_last));
    act_full_d = prom || (act_full_q && !(hs && at_last));
    sh_full_d  = cap || (sh_full_q && !prom);
    ptr_d      = ptr_q;
    if (prom || (hs && at_last)) begin
      ptr_d = '0;
    end else if (hs) begin
      ptr_d = ptr_q + IW'(1);
    end
    addr_d  = (BITREV != 0) ? IW'(bitrev(FFT_MAX_IW'(ptr_d), int'(IW))) : ptr_d;
    rd_re   = prom ? sh_re_q[addr_d] : act_re_q[addr_d];
    rd_im   = prom ? sh_im_q[addr_d] : act_im_q[addr_d];
    valid_d = act_full_d && pace_ready;
    load    = valid_d && ((state_q != ST_PRESENT) || hs);
    if (valid_d) begin
      state_d = ST_PRESENT;
    end else if (act_full_d) begin
      state_d = ST_WAIT;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Sequencer state, flags and registered beat outputs.
  always_ff @(posedge fastclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      act_full_q <= 1'b0;
      sh_full_q  <= 1'b0;
      out_re_q   <= '0;
      out_im_q   <= '0;
      index_q    <= '0;
      out_last_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      act_full_q <= act_full_d;
      sh_full_q  <= sh_full_d;
      if (frame_valid && sh_full_q) begin
        overrun_q <= 1'b1;
      end
      if (load) begin
        out_re_q   <= rd_re;
        out_im_q   <= ((addr_d == '0) || (addr_d == NYQ_BIN)) ? '0 : rd_im;
        index_q    <= addr_d;
        out_last_q <= (ptr_d == LAST_PTR);
      end else if (!valid_d) begin
        out_last_q <= 1'b0;
      end
    end
  end

  assign frame_ready = !sh_full_q;
  assign out_valid   = (state_q == ST_PRESENT);
  assign output_re   = out_re_q;
  assign output_im   = out_im_q;
  assign index       = index_q;
  assign out_last    = out_last_q;
  assign overrun     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_output_serializer.sv
// ============================================================================
// Module      : tb_fft_output_serializer
// Description : Directed self-checking bench for fft_output_serializer with
//               three instances: fast natural order, RATE_DIV=52, and
//               bit-reversed order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fft_output_serializer;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int IW = 3;

  logic           fastclk = 1'b0;
  logic           rst;
  logic [N*W-1:0] frame_re, frame_im;

  logic           fv_a, fr_a, ordy_a, ov_a, last_a, ovr_a;
  logic [W-1:0]   re_a, im_a;
  logic [IW-1:0]  idx_a;
  logic           fv_s, fr_s, ordy_s, ov_s, last_s, ovr_s;
  logic [W-1:0]   re_s, im_s;
  logic [IW-1:0]  idx_s;
  logic           fv_b, fr_b, ordy_b, ov_b, last_b, ovr_b;
  logic [W-1:0]   re_b, im_b;
  logic [IW-1:0]  idx_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 fastclk = ~fastclk;

  // Free-running cycle count for latency and spacing measurements.
  always @(posedge fastclk) cyc <= cyc + 1;

  fft_output_serializer #(.N(N), .W(W), .RATE_DIV(1), .BITREV(0)) u_dut_a (
    .fastclk(fastclk), .rst(rst), .frame_re(frame_re), .frame_im(frame_im),
    .frame_valid(fv_a), .frame_ready(fr_a), .output_re(re_a), .output_im(im_a),
    .index(idx_a), .out_valid(ov_a), .out_ready(ordy_a), .out_last(last_a),
    .overrun(ovr_a));

  fft_output_serializer #(.N(N), .W(W), .RATE_DIV(52), .BITREV(0)) u_dut_s (
    .fastclk(fastclk), .rst(rst), .frame_re(frame_re), .frame_im(frame_im),
    .frame_valid(fv_s), .frame_ready(fr_s), .output_re(re_s), .output_im(im_s),
    .index(idx_s), .out_valid(ov_s), .out_ready(ordy_s), .out_last(last_s),
    .overrun(ovr_s));

  fft_output_serializer #(.N(N), .W(W), .RATE_DIV(1), .BITREV(1)) u_dut_b (
    .fastclk(fastclk), .rst(rst), .frame_re(frame_re), .frame_im(frame_im),
    .frame_valid(fv_b), .frame_ready(fr_b), .output_re(re_b), .output_im(im_b),
    .index(idx_b), .out_valid(ov_b), .out_ready(ordy_b), .out_last(last_b),
    .overrun(ovr_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge fastclk);
    #1;
  endtask

  // Frame pattern: re = base + k*100, im = k*10 + 1.
  task automatic load_frame(input int base);
    for (int k = 0; k < N; k++) begin
      frame_re[k*W +: W] = W'(base + k*100);
      frame_im[k*W +: W] = W'(k*10 + 1);
    end
  endtask

  function automatic int exp_im(input int idx);
    return (idx == 0 || idx == N/2) ? 0 : idx*10 + 1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cap_cyc, first_cyc, nhs, cnt;
    int hs_cyc [8];
    int brev_seq [8];
    bit found;
    brev_seq = '{0, 4, 2, 6, 1, 5, 3, 7};

    rst = 1'b1;
    fv_a = 0; fv_s = 0; fv_b = 0;
    ordy_a = 1; ordy_s = 1; ordy_b = 1;
    load_frame(0);
    repeat (3) tick();

    // Reset state
    check("rst_valid", ov_a, 0);
    check("rst_last", last_a, 0);
    check("rst_re", re_a, 0);
    check("rst_im", im_a, 0);
    check("rst_index", idx_a, 0);
    check("rst_overrun", ovr_a, 0);
    check("rst_fready", fr_a, 1);
    rst = 1'b0;
    tick();

    // One frame, RATE_DIV=1, out_ready=1: eight consecutive beats
    fv_a = 1; tick(); fv_a = 0;
    check("t1_fready_low", fr_a, 0);
    tick();
    check("t1_fready_back", fr_a, 1);
    for (int b = 0; b < N; b++) begin
      check($sformatf("t1_valid%0d", b), ov_a, 1);
      check($sformatf("t1_index%0d", b), idx_a, b);
      check($sformatf("t1_re%0d", b), re_a, b*100);
      check($sformatf("t1_im%0d", b), im_a, exp_im(b));
      check($sformatf("t1_last%0d", b), last_a, (b == N-1) ? 1 : 0);
      tick();
    end
    check("t1_done", ov_a, 0);

    // Stall at index 3 for 10 cycles
    fv_a = 1; tick(); fv_a = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ov_a && idx_a == 3) found = 1; else tick();
    end
    check("t3_reach3", found, 1);
    ordy_a = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_valid", ov_a, 1);
      check("t3_hold_index", idx_a, 3);
      check("t3_hold_re", re_a, 300);
      check("t3_hold_im", im_a, 31);
      check("t3_hold_last", last_a, 0);
    end
    ordy_a = 1; tick();
    check("t3_next_index", idx_a, 4);
    check("t3_next_valid", ov_a, 1);
    for (int i = 0; i < 20 && ov_a; i++) tick();
    check("t3_drained", ov_a, 0);

    // Double buffering and overrun
    ordy_a = 0;
    load_frame(1000); fv_a = 1; tick(); fv_a = 0;
    tick();
    check("t4_fready_after_promote", fr_a, 1);
    load_frame(2000); fv_a = 1; tick();
    check("t4_fready_full", fr_a, 0);
    check("t4_no_overrun_yet", ovr_a, 0);
    load_frame(3000); tick(); fv_a = 0;
    check("t4_overrun", ovr_a, 1);
    check("t4_fready_still_low", fr_a, 0);
    check("t4_head_re", re_a, 1000);
    ordy_a = 1;
    for (int b = 0; b < 2*N; b++) begin
      check($sformatf("t4_valid%0d", b), ov_a, 1);
      check($sformatf("t4_index%0d", b), idx_a, b % N);
      check($sformatf("t4_re%0d", b), re_a, ((b < N) ? 1000 : 2000) + (b % N)*100);
      check($sformatf("t4_last%0d", b), last_a, ((b % N) == N-1) ? 1 : 0);
      tick();
    end
    check("t4_done", ov_a, 0);
    check("t4_overrun_sticky", ovr_a, 1);

    // RATE_DIV=52 spacing
    load_frame(0);
    fv_s = 1; tick(); fv_s = 0;
    cap_cyc = cyc; first_cyc = -1; nhs = 0;
    for (int i = 0; i < 600 && nhs < N; i++) begin
      if (ov_s && first_cyc < 0) first_cyc = cyc;
      if (ov_s && ordy_s) begin
        check($sformatf("t2_index%0d", nhs), idx_s, nhs);
        hs_cyc[nhs] = cyc;
        nhs++;
      end
      if (nhs < N) tick();
    end
    check("t2_beats", nhs, N);
    check("t2_first_latency", first_cyc - cap_cyc, 1);
    for (int b = 1; b < N; b++)
      check($sformatf("t2_spacing%0d", b), hs_cyc[b] - hs_cyc[b-1], 52);
    tick();
    check("t2_done", ov_s, 0);

    // Bit-reversed read order
    fv_b = 1; tick(); fv_b = 0; tick();
    for (int b = 0; b < N; b++) begin
      check($sformatf("t5_valid%0d", b), ov_b, 1);
      check($sformatf("t5_index%0d", b), idx_b, brev_seq[b]);
      check($sformatf("t5_re%0d", b), re_b, brev_seq[b]*100);
      check($sformatf("t5_im%0d", b), im_b, exp_im(brev_seq[b]));
      check($sformatf("t5_last%0d", b), last_b, (b == N-1) ? 1 : 0);
      tick();
    end

    // Reset mid-frame at index 5
    fv_a = 1; tick(); fv_a = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ov_a && idx_a == 5) found = 1; else tick();
    end
    check("t6_reach5", found, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", ov_a, 0);
    check("t6_overrun_clr", ovr_a, 0);
    @(posedge fastclk); #1 rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ov_a) cnt++;
    end
    check("t6_quiet", cnt, 0);
    fv_a = 1; tick(); fv_a = 0; tick();
    check("t6_restart_valid", ov_a, 1);
    check("t6_restart_index", idx_a, 0);
    check("t6_restart_re", re_a, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
